// File: rtl/connect4_pkg.sv
// Shared constants, state encodings and frame layout for the board snapshot UART link.
// The frame byte function is the single definition of what goes on the wire.
package connect4_pkg;

    localparam logic [7:0] SOF         = 8'hC4;
    localparam int         FRAME_BYTES = 7;
    localparam logic [2:0] LAST_BYTE   = 3'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic {
        FR_IDLE   = 1'b0,
        FR_ACTIVE = 1'b1
    } frame_state_e;

    typedef struct packed {
        logic [15:0] board;
        logic [15:0] cells;
        logic [1:0]  fsm;
        logic [1:0]  status;
        logic [3:0]  seq;
    } snapshot_t;

    // Byte idx of the frame built from a latched snapshot; byte 6 is the XOR of bytes 0..5.
    function automatic logic [7:0] frame_byte(input logic [2:0] idx, input snapshot_t s);
        logic [7:0] b5;
        logic [7:0] chk;
        logic [7:0] result;
        b5  = {s.seq, s.fsm, s.status};
        chk = SOF ^ s.board[7:0] ^ s.board[15:8] ^ s.cells[7:0] ^ s.cells[15:8] ^ b5;
        case (idx)
            3'd1:    result = s.board[7:0];
            3'd2:    result = s.board[15:8];
            3'd3:    result = s.cells[7:0];
            3'd4:    result = s.cells[15:8];
            3'd5:    result = b5;
            3'd6:    result = chk;
            default: result = SOF;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/board_tx_byte_serializer.sv
// 8N1 serializer for one byte with its own baud counter.
// A load in the last stop-bit cycle chains the next byte with no idle gap.
module board_tx_byte_serializer
    import connect4_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] byte_in,
    output logic       tx,
    output logic       byte_done
);

    localparam int            CW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          bit_end;

    assign bit_end = (baud_q == BAUD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= TX_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = bit_end ? '0 : baud_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        byte_done = 1'b0;

        case (state_q)
            TX_IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
            end
            TX_START: begin
                if (bit_end) begin
                    state_d   = TX_DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    byte_done = 1'b1;
                    state_d   = TX_IDLE;
                    tx_d      = 1'b1;
                end
            end
            default: begin
                state_d = TX_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // A new byte overrides whatever the current bit was doing.
        if (load) begin
            state_d   = TX_START;
            baud_d    = '0;
            bit_idx_d = 3'd0;
            shift_d   = byte_in;
            tx_d      = 1'b0;
        end
    end

    assign tx = tx_q;

endmodule

// File: rtl/board_uart_tx.sv
// Frame controller: latches a board snapshot on send and streams the 7-byte frame
// through the byte serializer, with one queued request and a 4-bit frame counter.
module board_uart_tx
    import connect4_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        send,
    input  logic [15:0] game_board,
    input  logic [15:0] player_cells,
    input  logic [1:0]  state,
    input  logic [1:0]  game_status,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    frame_state_e fsm_q, fsm_d;
    logic [2:0]   byte_idx_q, byte_idx_d;
    snapshot_t    snap_q, snap_d;
    logic [3:0]   seq_q, seq_d;
    logic         pending_q, pending_d;
    logic         done_q, done_d;

    logic         ser_load;
    logic [7:0]   ser_byte;
    logic         ser_byte_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q      <= FR_IDLE;
            byte_idx_q <= '0;
            snap_q     <= '0;
            seq_q      <= '0;
            pending_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            byte_idx_q <= byte_idx_d;
            snap_q     <= snap_d;
            seq_q      <= seq_d;
            pending_q  <= pending_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        fsm_d      = fsm_q;
        byte_idx_d = byte_idx_q;
        snap_d     = snap_q;
        seq_d      = seq_q;
        pending_d  = pending_q;
        done_d     = 1'b0;
        ser_load   = 1'b0;
        ser_byte   = SOF;

        case (fsm_q)
            FR_IDLE: begin
                // The done cycle is already idle, so a queued request restarts here.
                if (send || pending_q) begin
                    snap_d.board  = game_board;
                    snap_d.cells  = player_cells;
                    snap_d.fsm    = state;
                    snap_d.status = game_status;
                    snap_d.seq    = seq_q;
                    byte_idx_d    = 3'd0;
                    pending_d     = 1'b0;
                    fsm_d         = FR_ACTIVE;
                    ser_load      = 1'b1;
                    ser_byte      = SOF;
                end
            end
            FR_ACTIVE: begin
                if (send) begin
                    pending_d = 1'b1;
                end
                if (ser_byte_done) begin
                    if (byte_idx_q != LAST_BYTE) begin
                        byte_idx_d = byte_idx_q + 3'd1;
                        ser_load   = 1'b1;
                        ser_byte   = frame_byte(byte_idx_q + 3'd1, snap_q);
                    end else begin
                        fsm_d  = FR_IDLE;
                        done_d = 1'b1;
                        seq_d  = seq_q + 4'd1;
                    end
                end
            end
            default: begin
                fsm_d = FR_IDLE;
            end
        endcase
    end

    board_tx_byte_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_serializer (
        .clk      (clk),
        .rst_n    (reset),
        .load     (ser_load),
        .byte_in  (ser_byte),
        .tx       (tx),
        .byte_done(ser_byte_done)
    );

    assign busy = (fsm_q == FR_ACTIVE);
    assign done = done_q;

endmodule

// File: tb/tb_board_uart_tx.sv
// Bench for board_uart_tx at 4 clocks per bit: captures tx/busy/done per cycle,
// decodes the UART stream and compares against a frame model built from field values.
module tb_board_uart_tx;

    localparam int BIT = 4;

    logic        clk;
    logic        reset;
    logic        send;
    logic [15:0] game_board;
    logic [15:0] player_cells;
    logic [1:0]  state;
    logic [1:0]  game_status;
    logic        tx;
    logic        busy;
    logic        done;

    logic        tx_log[$];
    logic        busy_log[$];
    logic        done_log[$];
    logic [7:0]  got_bytes[$];
    logic [7:0]  exp_bytes[$];
    int          stop_errs;
    int          n_cmp;
    int          n_bad;
    logic [3:0]  exp_seq;

    board_uart_tx #(.CLKS_PER_BIT(BIT)) dut (
        .clk         (clk),
        .reset       (reset),
        .send        (send),
        .game_board  (game_board),
        .player_cells(player_cells),
        .state       (state),
        .game_status (game_status),
        .tx          (tx),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time expired, required completion");
        $fatal(1, "watchdog");
    end

    // Frame as the wire should carry it, built straight from field values.
    function automatic void model_frame(input logic [15:0] gb, input logic [15:0] pc,
                                        input logic [1:0] st, input logic [1:0] gs,
                                        input logic [3:0] sq);
        logic [7:0] b[7];
        b[0] = 8'hC4;
        b[1] = gb[7:0];
        b[2] = gb[15:8];
        b[3] = pc[7:0];
        b[4] = pc[15:8];
        b[5] = {sq, st, gs};
        b[6] = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5];
        for (int k = 0; k < 7; k++) exp_bytes.push_back(b[k]);
    endfunction

    // Sample n cycles on the falling edge; send stays high for hold cycles and pulses once more at extra_at.
    task automatic capture(input int n, input int hold, input int extra_at, input int change_at);
        tx_log.delete();
        busy_log.delete();
        done_log.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tx_log.push_back(tx);
            busy_log.push_back(busy);
            done_log.push_back(done);
            send = (i < hold - 1) || (i == extra_at);
            if (i == change_at) begin
                game_board   = 16'hFFFF;
                player_cells = 16'($urandom);
            end
        end
        send = 1'b0;
    endtask

    task automatic decode();
        int         i;
        logic [7:0] b;
        got_bytes.delete();
        stop_errs = 0;
        i = 0;
        while (i + 10 * BIT - 1 < tx_log.size()) begin
            if (tx_log[i] === 1'b0) begin
                for (int k = 0; k < 8; k++) b[k] = tx_log[i + BIT * (k + 1) + BIT / 2];
                if (tx_log[i + 9 * BIT + BIT / 2] !== 1'b1) stop_errs++;
                got_bytes.push_back(b);
                i = i + 9 * BIT + BIT / 2 + 1;
            end else begin
                i++;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        send  = 1'b0;
        repeat (3) @(negedge clk);
        reset   = 1'b1;
        exp_seq = 4'd0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        send  = 1'b0;
        game_board = '0; player_cells = '0; state = '0; game_status = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b required 1", tx); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b required 0", done); end
        reset   = 1'b1;
        exp_seq = 4'd0;
        @(negedge clk);
        n_cmp++; if (tx !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL idle_after_reset: tx=%b busy=%b required tx=1 busy=0", tx, busy); end
        $display("reset: checked idle outputs");
    endtask

    task automatic test_basic();
        logic [7:0] want[7];
        int nb;
        int nd;
        want = '{8'hC4, 8'h0F, 8'h00, 8'h05, 8'h00, 8'h04, 8'hCA};
        @(negedge clk);
        game_board = 16'h000F; player_cells = 16'h0005; state = 2'b01; game_status = 2'b00;
        send = 1'b1;
        capture(300, 1, -1, -1);
        decode();
        nb = 0; nd = 0;
        foreach (busy_log[i]) begin
            if (busy_log[i] === 1'b1) nb++;
            if (done_log[i] === 1'b1) nd++;
        end
        n_cmp++; if (tx_log[0] !== 1'b0 || busy_log[0] !== 1'b1) begin n_bad++; $display("FAIL basic_start: tx=%b busy=%b required tx=0 busy=1", tx_log[0], busy_log[0]); end
        n_cmp++; if (nb != 280) begin n_bad++; $display("FAIL basic_busy_len: got %0d required 280", nb); end
        n_cmp++; if (nd != 1) begin n_bad++; $display("FAIL basic_done_count: got %0d required 1", nd); end
        n_cmp++; if (done_log[280] !== 1'b1 || busy_log[280] !== 1'b0) begin n_bad++; $display("FAIL basic_done_cycle: done=%b busy=%b required done=1 busy=0", done_log[280], busy_log[280]); end
        n_cmp++; if (got_bytes.size() != 7) begin n_bad++; $display("FAIL basic_nbytes: got %0d required 7", got_bytes.size()); end
        for (int j = 0; j < 7 && j < got_bytes.size(); j++) begin
            n_cmp++; if (got_bytes[j] !== want[j]) begin n_bad++; $display("FAIL basic_byte%0d: got %02h required %02h", j, got_bytes[j], want[j]); end
        end
        n_cmp++; if (stop_errs != 0) begin n_bad++; $display("FAIL basic_stop_bits: got %0d bad stop bits required 0", stop_errs); end
        exp_seq++;
        $display("basic: %0d bytes decoded, busy %0d cycles, done %0d", got_bytes.size(), nb, nd);
    endtask

    task automatic test_bit_timing();
        logic        wave[$];
        logic [15:0] gb;
        logic [15:0] pc;
        logic [1:0]  st;
        logic [1:0]  gs;
        int          diffs;
        int          first_high;
        gb = 16'($urandom); pc = 16'($urandom); st = 2'($urandom); gs = 2'($urandom);
        @(negedge clk);
        game_board = gb; player_cells = pc; state = st; game_status = gs;
        send = 1'b1;
        capture(290, 1, -1, -1);
        exp_bytes.delete();
        model_frame(gb, pc, st, gs, exp_seq);
        foreach (exp_bytes[j]) begin
            for (int c = 0; c < BIT; c++) wave.push_back(1'b0);
            for (int k = 0; k < 8; k++)
                for (int c = 0; c < BIT; c++) wave.push_back(exp_bytes[j][k]);
            for (int c = 0; c < BIT; c++) wave.push_back(1'b1);
        end
        diffs = 0;
        foreach (wave[i]) if (tx_log[i] !== wave[i]) diffs++;
        n_cmp++; if (diffs != 0) begin n_bad++; $display("FAIL timing_waveform: %0d cycles differ required 0", diffs); end
        first_high = -1;
        for (int i = 0; i < 40 && first_high < 0; i++) if (tx_log[i] === 1'b1) first_high = i;
        n_cmp++; if (first_high != 12) begin n_bad++; $display("FAIL timing_first_high: got %0d required 12", first_high); end
        n_cmp++; if (tx_log[16] !== 1'b0 || tx_log[15] !== 1'b1) begin n_bad++; $display("FAIL timing_bit2_len: tx[15]=%b tx[16]=%b required 1,0", tx_log[15], tx_log[16]); end
        n_cmp++; if (tx_log[280] !== 1'b1) begin n_bad++; $display("FAIL timing_idle_after: got %b required 1", tx_log[280]); end
        exp_seq++;
        $display("bit_timing: seq field %0d, %0d waveform cycles differ", exp_seq - 4'd1, diffs);
    endtask

    task automatic test_snapshot_hold();
        logic [15:0] pc;
        logic [1:0]  st;
        logic [1:0]  gs;
        pc = 16'($urandom); st = 2'($urandom); gs = 2'($urandom);
        @(negedge clk);
        game_board = 16'h000F; player_cells = pc; state = st; game_status = gs;
        send = 1'b1;
        capture(300, 1, -1, 5);
        decode();
        exp_bytes.delete();
        model_frame(16'h000F, pc, st, gs, exp_seq);
        n_cmp++; if (got_bytes.size() != 7) begin n_bad++; $display("FAIL hold_nbytes: got %0d required 7", got_bytes.size()); end
        for (int j = 0; j < 7 && j < got_bytes.size(); j++) begin
            n_cmp++; if (got_bytes[j] !== exp_bytes[j]) begin n_bad++; $display("FAIL hold_byte%0d: got %02h required %02h", j, got_bytes[j], exp_bytes[j]); end
        end
        exp_seq++;
        $display("snapshot_hold: B1=%02h B2=%02h after board changed mid-frame", got_bytes.size() > 2 ? got_bytes[1] : 8'h00, got_bytes.size() > 2 ? got_bytes[2] : 8'h00);
    endtask

    task automatic test_back_to_back();
        logic [15:0] gb;
        logic [15:0] pc;
        logic [1:0]  st;
        logic [1:0]  gs;
        int          nd;
        do_reset();
        gb = 16'($urandom); pc = 16'($urandom); st = 2'($urandom); gs = 2'($urandom);
        @(negedge clk);
        game_board = gb; player_cells = pc; state = st; game_status = gs;
        send = 1'b1;
        capture(600, 3, 130, -1);
        decode();
        exp_bytes.delete();
        model_frame(gb, pc, st, gs, exp_seq);
        model_frame(gb, pc, st, gs, exp_seq + 4'd1);
        nd = 0;
        foreach (done_log[i]) if (done_log[i] === 1'b1) nd++;
        n_cmp++; if (nd != 2) begin n_bad++; $display("FAIL b2b_done_count: got %0d required 2", nd); end
        n_cmp++; if (got_bytes.size() != 14) begin n_bad++; $display("FAIL b2b_nbytes: got %0d required 14", got_bytes.size()); end
        for (int j = 0; j < 14 && j < got_bytes.size(); j++) begin
            n_cmp++; if (got_bytes[j] !== exp_bytes[j]) begin n_bad++; $display("FAIL b2b_byte%0d: got %02h required %02h", j, got_bytes[j], exp_bytes[j]); end
        end
        n_cmp++; if (done_log[280] !== 1'b1 || tx_log[280] !== 1'b1 || busy_log[280] !== 1'b0) begin n_bad++; $display("FAIL b2b_gap: done=%b tx=%b busy=%b required 1,1,0", done_log[280], tx_log[280], busy_log[280]); end
        n_cmp++; if (tx_log[281] !== 1'b0 || busy_log[281] !== 1'b1) begin n_bad++; $display("FAIL b2b_restart: tx=%b busy=%b required tx=0 busy=1", tx_log[281], busy_log[281]); end
        n_cmp++; if (done_log[561] !== 1'b1) begin n_bad++; $display("FAIL b2b_second_done: got %b required 1", done_log[561]); end
        if (got_bytes.size() == 14) begin
            n_cmp++; if (got_bytes[5][7:4] !== 4'd0 || got_bytes[12][7:4] !== 4'd1) begin n_bad++; $display("FAIL b2b_seq: got %0d,%0d required 0,1", got_bytes[5][7:4], got_bytes[12][7:4]); end
        end
        exp_seq = exp_seq + 4'd2;
        $display("back_to_back: %0d frames done, %0d bytes decoded", nd, got_bytes.size());
    endtask

    task automatic test_wrap();
        logic [15:0] gb;
        logic [15:0] pc;
        logic [1:0]  st;
        logic [1:0]  gs;
        do_reset();
        for (int f = 0; f < 17; f++) begin
            gb = 16'($urandom); pc = 16'($urandom); st = 2'($urandom); gs = 2'($urandom);
            @(negedge clk);
            game_board = gb; player_cells = pc; state = st; game_status = gs;
            send = 1'b1;
            capture(285, 1, -1, -1);
            decode();
            exp_bytes.delete();
            model_frame(gb, pc, st, gs, exp_seq);
            n_cmp++;
            if (got_bytes.size() != 7 || got_bytes[5] !== exp_bytes[5] || got_bytes[6] !== exp_bytes[6]) begin
                n_bad++;
                $display("FAIL wrap_frame%0d: nbytes=%0d B5=%02h B6=%02h required 7,%02h,%02h", f, got_bytes.size(),
                         got_bytes.size() > 6 ? got_bytes[5] : 8'hxx, got_bytes.size() > 6 ? got_bytes[6] : 8'hxx, exp_bytes[5], exp_bytes[6]);
            end
            if (f == 16) begin
                n_cmp++; if (got_bytes.size() != 7 || got_bytes[5][7:4] !== 4'd0) begin n_bad++; $display("FAIL wrap_seq17: got %0d required 0", got_bytes.size() > 5 ? got_bytes[5][7:4] : 4'hx); end
            end
            $display("wrap: frame %0d seq field expected %0d", f, exp_seq);
            exp_seq = exp_seq + 4'd1;
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] gb;
        logic [15:0] pc;
        logic [1:0]  st;
        logic [1:0]  gs;
        int          bad_idle;
        int          nd;
        do_reset();
        @(negedge clk);
        game_board = 16'($urandom); player_cells = 16'($urandom); state = 2'($urandom); game_status = 2'($urandom);
        send = 1'b1;
        capture(90, 1, -1, -1);
        n_cmp++; if (busy_log[89] !== 1'b1) begin n_bad++; $display("FAIL rst_mid_busy_before: got %b required 1", busy_log[89]); end
        reset = 1'b0;
        #1;
        n_cmp++; if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL rst_mid_immediate: tx=%b busy=%b done=%b required 1,0,0", tx, busy, done); end
        bad_idle = 0;
        repeat (4) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad_idle++;
        end
        n_cmp++; if (bad_idle != 0) begin n_bad++; $display("FAIL rst_mid_held: %0d bad cycles required 0", bad_idle); end
        gb = 16'($urandom); pc = 16'($urandom); st = 2'($urandom); gs = 2'($urandom);
        reset = 1'b1;
        game_board = gb; player_cells = pc; state = st; game_status = gs;
        send = 1'b1;
        capture(300, 1, -1, -1);
        decode();
        exp_bytes.delete();
        model_frame(gb, pc, st, gs, exp_seq);
        n_cmp++; if (tx_log[0] !== 1'b0 || busy_log[0] !== 1'b1) begin n_bad++; $display("FAIL rst_first_edge_send: tx=%b busy=%b required 0,1", tx_log[0], busy_log[0]); end
        n_cmp++; if (got_bytes.size() != 7) begin n_bad++; $display("FAIL rst_nbytes: got %0d required 7", got_bytes.size()); end
        for (int j = 0; j < 7 && j < got_bytes.size(); j++) begin
            n_cmp++; if (got_bytes[j] !== exp_bytes[j]) begin n_bad++; $display("FAIL rst_byte%0d: got %02h required %02h", j, got_bytes[j], exp_bytes[j]); end
        end
        nd = 0;
        foreach (done_log[i]) if (done_log[i] === 1'b1) nd++;
        n_cmp++; if (nd != 1) begin n_bad++; $display("FAIL rst_done_count: got %0d required 1", nd); end
        exp_seq++;
        $display("reset_mid_frame: next frame decoded with %0d bytes", got_bytes.size());
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        exp_seq = 4'd0;
        send = 1'b0;
        reset = 1'b0;
        test_reset();
        test_basic();
        test_bit_timing();
        test_snapshot_hold();
        test_back_to_back();
        test_wrap();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
